sar_seq_ctrl: RTL and testbench

Digital SAR conversion sequencer driving the four `seq_*` timing inputs of the FRIDA 65 core and capturing its serial `comp_out` decisions into parallel words. Sits on the readout FPGA, directly upstream (sequencing) and downstream (data) of the chip core, across the LVDS links. Phase durations come from configuration registers. Completed words are handed to the DAQ through a valid/ready interface.

---
 rtl/sar_seq_ctrl_pkg.sv | 21 ++
 rtl/sar_seq_ctrl_if.sv | 11 +
 rtl/sar_seq_ctrl_sync2.sv | 20 ++
 rtl/sar_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_seq_ctrl_pkg.sv
// Shared types and constants for the FRIDA SAR conversion sequencer.
package frida_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SAMP,
    ST_CMP,
    ST_LOGIC
  } seq_state_e;

  localparam int MIN_LOGIC_LEN = 3;
  localparam int DEF_NBITS     = 12;
  localparam int DEF_LEN_W     = 8;

  // Effective phase length: a zero or too-short config field is raised to min_len.
  function automatic int unsigned eff_len(input int unsigned cfg, input int unsigned min_len);
    return (cfg < min_len) ? min_len : cfg;
  endfunction

endpackage

// File: rtl/sar_seq_ctrl_if.sv
// Output word handshake between the sequencer and the DAQ.
interface sar_seq_ctrl_if #(
  parameter int NBITS = frida_seq_pkg::DEF_NBITS
);
  logic [NBITS-1:0] data;
  logic             data_valid;
  logic             data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/sar_seq_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs from the LVDS links.
module frida_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q, ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= '0;
    else       ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/sar_seq_ctrl.sv
// SAR conversion sequencer: drives the seq_* phase strobes and assembles comp_out decisions into words.
//   state | meaning
//   IDLE  | waiting for start, all strobes low
//   INIT  | seq_init, config shadows latched on entry
//   SAMP  | seq_samp, input sampling
//   CMP   | seq_cmp, comparator decision for the current bit
//   LOGIC | seq_logic, decision captured in the last cycle
module sar_seq_ctrl
  import frida_seq_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_init_len,
  input  logic [LEN_W-1:0] cfg_samp_len,
  input  logic [LEN_W-1:0] cfg_cmp_len,
  input  logic [LEN_W-1:0] cfg_logic_len,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_cmp,
  output logic             seq_logic,
  input  logic             comp_out,
  sar_seq_ctrl_if.master   dout,
  output logic             busy,
  output logic             overrun
);

  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] samp_sh_q, samp_sh_d;
  logic [LEN_W-1:0] cmp_sh_q, cmp_sh_d;
  logic [LEN_W-1:0] logic_sh_q, logic_sh_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             s_init_q, s_samp_q, s_cmp_q, s_logic_q;
  logic             comp_sync;
  logic             done_word;
  logic             latch_cfg;

  // Counter load value: phase ends when the down-counter reaches zero.
  function automatic logic [LEN_W-1:0] load_val(input logic [LEN_W-1:0] cfg, input int unsigned min_len);
    return LEN_W'(eff_len(32'(cfg), min_len) - 32'd1);
  endfunction

  frida_sync2 u_sync_comp (
    .clk   (clk),
    .reset (reset),
    .d     (comp_out),
    .q     (comp_sync)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    samp_sh_d  = samp_sh_q;
    cmp_sh_d   = cmp_sh_q;
    logic_sh_d = logic_sh_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    done_word  = 1'b0;
    latch_cfg  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT;
          cnt_d     = load_val(cfg_init_len, 1);
          latch_cfg = 1'b1;
          ovr_d     = 1'b0;
        end
      end
      ST_INIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMP;
          cnt_d   = load_val(samp_sh_q, 1);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_SAMP: begin
        if (cnt_q == '0) begin
          state_d = ST_CMP;
          cnt_d   = load_val(cmp_sh_q, 1);
          bit_d   = BIT_W'(NBITS - 1);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_CMP: begin
        if (cnt_q == '0) begin
          state_d = ST_LOGIC;
          cnt_d   = load_val(logic_sh_q, MIN_LOGIC_LEN);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_LOGIC: begin
        if (cnt_q == '0) begin
          shift_d = NBITS'({shift_q, comp_sync});
          if (bit_q == '0) begin
            done_word = 1'b1;
            if (continuous) begin
              state_d   = ST_INIT;
              cnt_d     = load_val(cfg_init_len, 1);
              latch_cfg = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            state_d = ST_CMP;
            cnt_d   = load_val(cmp_sh_q, 1);
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort beats everything, including a start in the same cycle and a word about to complete.
    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      bit_d     = '0;
      shift_d   = '0;
      done_word = 1'b0;
      latch_cfg = 1'b0;
      ovr_d     = ovr_q;
    end

    if (latch_cfg) begin
      samp_sh_d  = cfg_samp_len;
      cmp_sh_d   = cfg_cmp_len;
      logic_sh_d = cfg_logic_len;
    end

    if (valid_q && dout.data_ready) valid_d = 1'b0;
    if (done_word) begin
      data_d  = shift_d;
      valid_d = 1'b1;
      if (valid_q && !dout.data_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      samp_sh_q  <= '0;
      cmp_sh_q   <= '0;
      logic_sh_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      s_init_q   <= 1'b0;
      s_samp_q   <= 1'b0;
      s_cmp_q    <= 1'b0;
      s_logic_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      samp_sh_q  <= samp_sh_d;
      cmp_sh_q   <= cmp_sh_d;
      logic_sh_q <= logic_sh_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      s_init_q   <= (state_d == ST_INIT);
      s_samp_q   <= (state_d == ST_SAMP);
      s_cmp_q    <= (state_d == ST_CMP);
      s_logic_q  <= (state_d == ST_LOGIC);
    end
  end

  assign seq_init        = s_init_q;
  assign seq_samp        = s_samp_q;
  assign seq_cmp         = s_cmp_q;
  assign seq_logic       = s_logic_q;
  assign dout.data       = data_q;
  assign dout.data_valid = valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl against a cycle-schedule reference model.
module tb_sar_seq_ctrl;

  localparam int NB = 12;
  localparam int LW = 8;

  typedef struct packed {
    logic [7:0] li;
    logic [7:0] ls;
    logic [7:0] lc;
    logic [7:0] ll;
  } cfg_t;

  localparam cfg_t C_BASIC = '{li: 8'd2, ls: 8'd4, lc: 8'd1, ll: 8'd3};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_init_len = '0;
  logic [LW-1:0] cfg_samp_len = '0;
  logic [LW-1:0] cfg_cmp_len = '0;
  logic [LW-1:0] cfg_logic_len = '0;
  logic          seq_init, seq_samp, seq_cmp, seq_logic;
  logic          comp_out = 1'b0;
  logic          busy, overrun;

  sar_seq_ctrl_if #(.NBITS(NB)) dif ();

  sar_seq_ctrl #(.NBITS(NB), .LEN_W(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .cfg_init_len  (cfg_init_len),
    .cfg_samp_len  (cfg_samp_len),
    .cfg_cmp_len   (cfg_cmp_len),
    .cfg_logic_len (cfg_logic_len),
    .seq_init      (seq_init),
    .seq_samp      (seq_samp),
    .seq_cmp       (seq_cmp),
    .seq_logic     (seq_logic),
    .comp_out      (comp_out),
    .dout          (dif),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          m_dv = 1'b0;
  logic [NB-1:0] m_data = '0;
  logic          m_ovr = 1'b0;

  function automatic int eff(input logic [7:0] v, input int m);
    return (int'(v) < m) ? m : int'(v);
  endfunction

  function automatic int conv_len(input cfg_t c);
    return eff(c.li, 1) + eff(c.ls, 1) + NB * (eff(c.lc, 1) + eff(c.ll, 3));
  endfunction

  // Phase of cycle r (1..T) within one conversion: 1 INIT, 2 SAMP, 3 CMP, 4 LOGIC; dec = decision index, 0 = MSB.
  function automatic int phase_in(input cfg_t c, input int r, output int dec);
    int li, ls, lb;
    li  = eff(c.li, 1);
    ls  = eff(c.ls, 1);
    lb  = eff(c.lc, 1) + eff(c.ll, 3);
    dec = 0;
    if (r <= li) return 1;
    if (r <= li + ls) return 2;
    dec = (r - li - ls - 1) / lb;
    return (((r - li - ls - 1) % lb) < eff(c.lc, 1)) ? 3 : 4;
  endfunction

  task automatic set_cfg(input cfg_t c);
    cfg_init_len  = c.li;
    cfg_samp_len  = c.ls;
    cfg_cmp_len   = c.lc;
    cfg_logic_len = c.ll;
  endtask

  // One start pulse, one or two (continuous) conversions. ca applies to the first conversion,
  // cb is written from cycle 3 on and so governs the second. abort_k < 0 means no abort.
  // ready_mode: 0 never ready, 1 always ready, 2 ready only in cycle ready_k.
  task automatic run_job(input string name, input int n_conv, input cfg_t ca, input cfg_t cb,
                         input logic [NB-1:0] w0, input logic [NB-1:0] w1,
                         input int ready_mode, input int ready_k, input int abort_k);
    int            s[2];
    int            e[2];
    cfg_t          cl[2];
    logic [NB-1:0] w[2];
    int            kend, ph, dec, j;
    logic          rdy, cmpl;
    logic [NB-1:0] wc;
    logic [4:0]    exp_v, got_v;
    cl[0] = ca;  cl[1] = cb;
    w[0]  = w0;  w[1]  = w1;
    s[0]  = 1;
    e[0]  = conv_len(ca);
    s[1]  = e[0] + 1;
    e[1]  = e[0] + conv_len(cb);
    kend  = e[n_conv-1] + 6;

    @(negedge clk);
    start          = 1'b1;
    abort          = (abort_k == 0);
    continuous     = (n_conv == 2);
    set_cfg(ca);
    rdy            = (ready_mode == 1) || (ready_mode == 2 && ready_k == 0);
    dif.data_ready = rdy;
    comp_out       = 1'($urandom % 2);
    if (abort_k != 0) m_ovr = 1'b0;
    if (m_dv && rdy) m_dv = 1'b0;

    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      start = 1'b0;
      ph = 0; dec = 0; j = -1;
      for (int c = 0; c < n_conv; c++) begin
        if (k >= s[c] && k <= e[c] && (abort_k < 0 || k <= abort_k)) begin
          j  = c;
          ph = phase_in(cl[c], k - s[c] + 1, dec);
        end
      end
      exp_v = {ph == 1, ph == 2, ph == 3, ph == 4, ph != 0};
      got_v = {seq_init, seq_samp, seq_cmp, seq_logic, busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s strobes/busy cycle %0d got %b exp %b", name, k, got_v, exp_v);
      end
      checks++;
      if (dif.data_valid !== m_dv) begin
        errors++;
        $display("FAIL %s data_valid cycle %0d got %b exp %b", name, k, dif.data_valid, m_dv);
      end
      checks++;
      if (overrun !== m_ovr) begin
        errors++;
        $display("FAIL %s overrun cycle %0d got %b exp %b", name, k, overrun, m_ovr);
      end
      checks++;
      if (dif.data !== m_data) begin
        errors++;
        $display("FAIL %s data cycle %0d got %h exp %h", name, k, dif.data, m_data);
      end

      abort      = (k == abort_k);
      continuous = (n_conv == 2) && (k <= e[0]);
      if (k >= 3) set_cfg(cb);
      else        set_cfg(ca);
      rdy = (ready_mode == 1) || (ready_mode == 2 && ready_k == k);
      dif.data_ready = rdy;
      if (j >= 0 && ph >= 3) comp_out = w[j][NB-1-dec];
      else                   comp_out = 1'($urandom % 2);

      cmpl = 1'b0;
      wc   = '0;
      for (int c = 0; c < n_conv; c++) begin
        if (k == e[c] && (abort_k < 0 || abort_k > k)) begin
          cmpl = 1'b1;
          wc   = w[c];
        end
      end
      if (cmpl) begin
        if (m_dv && !rdy) m_ovr = 1'b1;
        m_data = wc;
        m_dv   = 1'b1;
      end else if (m_dv && rdy) begin
        m_dv = 1'b0;
      end
    end
    abort          = 1'b0;
    continuous     = 1'b0;
    dif.data_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] v;
    repeat (3) @(negedge clk);
    v = {seq_init, seq_samp, seq_cmp, seq_logic, busy, dif.data_valid, overrun, dif.data == '0, 1'b1};
    checks++;
    if (v !== 9'b000000011) begin
      errors++;
      $display("FAIL reset_held outputs got %b exp %b", v, 9'b000000011);
    end
    reset = 1'b0;
    @(negedge clk);
    v = {seq_init, seq_samp, seq_cmp, seq_logic, busy, dif.data_valid, overrun, dif.data == '0, 1'b1};
    checks++;
    if (v !== 9'b000000011) begin
      errors++;
      $display("FAIL reset_released outputs got %b exp %b", v, 9'b000000011);
    end
  endtask

  task automatic test_basic();
    run_job("basic", 1, C_BASIC, C_BASIC, 12'hA5C, '0, 2, conv_len(C_BASIC) + 3, -1);
  endtask

  task automatic test_min_len();
    run_job("min_len", 1, '0, '0, 12'($urandom), '0, 1, 0, -1);
  endtask

  task automatic test_random();
    cfg_t ca, cb;
    for (int i = 0; i < 3; i++) begin
      ca = '{li: 8'($urandom_range(0, 5)), ls: 8'($urandom_range(0, 5)),
             lc: 8'($urandom_range(0, 4)), ll: 8'($urandom_range(0, 5))};
      cb = '{li: 8'($urandom_range(0, 5)), ls: 8'($urandom_range(0, 5)),
             lc: 8'($urandom_range(0, 4)), ll: 8'($urandom_range(0, 5))};
      run_job("random", 2, ca, cb, 12'($urandom), 12'($urandom), 1, 0, -1);
    end
  endtask

  task automatic test_overrun();
    run_job("overrun", 2, C_BASIC, C_BASIC, 12'h5A3, 12'h9C6, 0, 0, -1);
    run_job("overrun_clear", 1, C_BASIC, C_BASIC, 12'h0F1, '0, 1, 0, -1);
  endtask

  task automatic test_abort();
    int ab;
    // first CMP cycle of the decision taken while the bit counter reads 5
    ab = eff(C_BASIC.li, 1) + eff(C_BASIC.ls, 1) + (NB - 1 - 5) * (eff(C_BASIC.lc, 1) + eff(C_BASIC.ll, 3)) + 1;
    run_job("abort_bit5", 1, C_BASIC, C_BASIC, 12'hFFF, '0, 0, 0, ab);
    run_job("start_abort", 1, C_BASIC, C_BASIC, 12'hFFF, '0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    cfg_t cb;
    cb    = C_BASIC;
    cb.ls = 8'd7;
    run_job("back_to_back", 2, C_BASIC, cb, 12'h3C5, 12'hB2E, 2,
            conv_len(C_BASIC) + conv_len(cb), -1);
  endtask

  task automatic test_reset_mid();
    logic [6:0] v;
    @(negedge clk);
    start = 1'b1;
    set_cfg(C_BASIC);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start    = 1'b0;
      comp_out = 1'($urandom % 2);
    end
    checks++;
    if (seq_samp !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid precondition seq_samp got %b exp 1", seq_samp);
    end
    #1 reset = 1'b1;
    #1;
    v = {seq_init, seq_samp, seq_cmp, seq_logic, busy, dif.data_valid, overrun};
    checks++;
    if (v !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b exp %b", v, 7'b0);
    end
    checks++;
    if (dif.data !== '0) begin
      errors++;
      $display("FAIL reset_mid data got %h exp %h", dif.data, 12'h000);
    end
    m_dv = 1'b0; m_ovr = 1'b0; m_data = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, dif.data_valid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_after busy/valid cycle %0d got %b exp 00", k, {busy, dif.data_valid});
      end
    end
  endtask

  initial begin
    dif.data_ready = 1'b0;
    test_reset();
    test_basic();
    test_min_len();
    test_random();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
